// File: rtl/node_tag_issuer.sv
// node_tag_issuer
// Transmit side of the tensor-core common bus. Accepts one strided-transfer
// command at a time, reads A/B block pairs from the scratchpad and presents
// them as tagged beats on the tagA/tagB/d0/d1 bus. Read data comes back one
// cycle after the strobe and lands in an output register, with a single-entry
// skid buffer behind it so that a read already in flight when the bus stalls
// is never lost. An empty output register always shows the NULL tag, so
// stripes can never latch from an idle bus.
module node_tag_issuer #(
    parameter int data_width  = 16,
    parameter int block_width = 128,
    parameter int tag_width   = 16,
    parameter int count_width = 12,
    parameter int addr_width  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [tag_width-1:0]   cmd_tag_a,
    input  logic [tag_width-1:0]   cmd_stride_a,
    input  logic [tag_width-1:0]   cmd_tag_b,
    input  logic [tag_width-1:0]   cmd_stride_b,
    input  logic [count_width-1:0] cmd_count,
    output logic                   mem_rd_en,
    output logic [addr_width-1:0]  mem_addr_a,
    output logic [addr_width-1:0]  mem_addr_b,
    input  logic [block_width-1:0] mem_data_a,
    input  logic [block_width-1:0] mem_data_b,
    input  logic                   bus_stall,
    output logic                   bus_valid,
    output logic [tag_width-1:0]   tagA_OUT,
    output logic [tag_width-1:0]   tagB_OUT,
    output logic [block_width-1:0] d0_OUT,
    output logic [block_width-1:0] d1_OUT,
    output logic                   done,
    output logic                   err_null_tag
);

    localparam int lanes = block_width / data_width;
    localparam logic [tag_width-1:0] null_tag = {tag_width{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Command context: running tags, strides and beats still to generate.
    logic [tag_width-1:0]   tag_a_reg;
    logic [tag_width-1:0]   tag_b_reg;
    logic [tag_width-1:0]   stride_a_reg;
    logic [tag_width-1:0]   stride_b_reg;
    logic [count_width-1:0] remaining_reg;
    logic                   err_reg;
    logic                   done_zero_reg;

    // Tags travelling alongside the outstanding scratchpad read.
    logic                   pipe_valid_reg;
    logic [tag_width-1:0]   pipe_tag_a_reg;
    logic [tag_width-1:0]   pipe_tag_b_reg;

    // Output register and skid buffer tag halves (data halves live per lane).
    logic                   out_valid_reg;
    logic                   out_valid_next;
    logic [tag_width-1:0]   out_tag_a_reg;
    logic [tag_width-1:0]   out_tag_b_reg;
    logic                   skid_valid_reg;
    logic                   skid_valid_next;
    logic [tag_width-1:0]   skid_tag_a_reg;
    logic [tag_width-1:0]   skid_tag_b_reg;

    logic cmd_accept;
    logic issue_slot;
    logic cur_null;
    logic read_fire;
    logic out_free;
    logic pipeline_empty;
    logic drain_done;
    logic skid_to_out;
    logic pipe_to_out;
    logic pipe_to_skid;

    // A beat slot is consumed only when the bus is moving and the skid is
    // empty; that guarantees the skid has room for the read it launches.
    assign cmd_accept     = (state_reg == ST_IDLE) && cmd_valid;
    assign issue_slot     = (state_reg == ST_ISSUE) && !bus_stall && !skid_valid_reg;
    assign cur_null       = (tag_a_reg == null_tag) || (tag_b_reg == null_tag);
    assign read_fire      = issue_slot && !cur_null;
    assign out_free       = !out_valid_reg || !bus_stall;
    assign pipeline_empty = !out_valid_reg && !skid_valid_reg && !pipe_valid_reg;

    assign cmd_ready    = (state_reg == ST_IDLE);
    assign mem_rd_en    = read_fire;
    assign mem_addr_a   = tag_a_reg[addr_width-1:0];
    assign mem_addr_b   = tag_b_reg[addr_width-1:0];
    assign done         = done_zero_reg || drain_done;
    assign err_null_tag = err_reg;

    assign bus_valid = out_valid_reg;
    assign tagA_OUT  = out_valid_reg ? out_tag_a_reg : null_tag;
    assign tagB_OUT  = out_valid_reg ? out_tag_b_reg : null_tag;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the drain-complete pulse is the cycle we leave DRAIN.
    always_comb begin
        state_next = state_reg;
        drain_done = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid && (cmd_count != '0)) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_slot && (remaining_reg == count_width'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipeline_empty) begin
                    drain_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the command on accept, then step tags and count once per slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_a_reg     <= null_tag;
            tag_b_reg     <= null_tag;
            stride_a_reg  <= '0;
            stride_b_reg  <= '0;
            remaining_reg <= '0;
            err_reg       <= 1'b0;
            done_zero_reg <= 1'b0;
        end else begin
            done_zero_reg <= cmd_accept && (cmd_count == '0);
            if (cmd_accept) begin
                tag_a_reg     <= cmd_tag_a;
                tag_b_reg     <= cmd_tag_b;
                stride_a_reg  <= cmd_stride_a;
                stride_b_reg  <= cmd_stride_b;
                remaining_reg <= cmd_count;
                err_reg       <= 1'b0;
            end else if (issue_slot) begin
                tag_a_reg     <= tag_a_reg + stride_a_reg;
                tag_b_reg     <= tag_b_reg + stride_b_reg;
                remaining_reg <= remaining_reg - count_width'(1);
                if (cur_null) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    // Carry the tags of the outstanding read so they meet its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg <= 1'b0;
            pipe_tag_a_reg <= null_tag;
            pipe_tag_b_reg <= null_tag;
        end else begin
            pipe_valid_reg <= read_fire;
            if (read_fire) begin
                pipe_tag_a_reg <= tag_a_reg;
                pipe_tag_b_reg <= tag_b_reg;
            end
        end
    end

    // Routing of returning data: the skid always refills the output first so
    // beat order is kept; fresh data goes to the output only when the skid is
    // empty and the output is free, otherwise it parks in the skid.
    always_comb begin
        skid_to_out  = skid_valid_reg && out_free;
        pipe_to_out  = pipe_valid_reg && out_free && !skid_valid_reg;
        pipe_to_skid = pipe_valid_reg && !pipe_to_out;
        if (out_free) begin
            out_valid_next = skid_valid_reg || pipe_valid_reg;
        end else begin
            out_valid_next = 1'b1;
        end
        skid_valid_next = pipe_to_skid || (skid_valid_reg && !skid_to_out);
    end

    // Output and skid valid flags plus their tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_tag_a_reg  <= null_tag;
            out_tag_b_reg  <= null_tag;
            skid_valid_reg <= 1'b0;
            skid_tag_a_reg <= null_tag;
            skid_tag_b_reg <= null_tag;
        end else begin
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            if (skid_to_out) begin
                out_tag_a_reg <= skid_tag_a_reg;
                out_tag_b_reg <= skid_tag_b_reg;
            end else if (pipe_to_out) begin
                out_tag_a_reg <= pipe_tag_a_reg;
                out_tag_b_reg <= pipe_tag_b_reg;
            end
            if (pipe_to_skid) begin
                skid_tag_a_reg <= pipe_tag_a_reg;
                skid_tag_b_reg <= pipe_tag_b_reg;
            end
        end
    end

    // Per-element data path: each lane of d0/d1 has its own output and skid
    // register, all steered by the shared routing decisions above.
    generate
        for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
            logic [data_width-1:0] out_a_reg;
            logic [data_width-1:0] out_b_reg;
            logic [data_width-1:0] skid_a_reg;
            logic [data_width-1:0] skid_b_reg;

            // Load this lane from the skid or from the scratchpad return.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_a_reg  <= '0;
                    out_b_reg  <= '0;
                    skid_a_reg <= '0;
                    skid_b_reg <= '0;
                end else begin
                    if (skid_to_out) begin
                        out_a_reg <= skid_a_reg;
                        out_b_reg <= skid_b_reg;
                    end else if (pipe_to_out) begin
                        out_a_reg <= mem_data_a[gi*data_width +: data_width];
                        out_b_reg <= mem_data_b[gi*data_width +: data_width];
                    end
                    if (pipe_to_skid) begin
                        skid_a_reg <= mem_data_a[gi*data_width +: data_width];
                        skid_b_reg <= mem_data_b[gi*data_width +: data_width];
                    end
                end
            end

            assign d0_OUT[gi*data_width +: data_width] = out_a_reg;
            assign d1_OUT[gi*data_width +: data_width] = out_b_reg;
        end
    endgenerate

endmodule

// File: tb/tb_node_tag_issuer.sv
// Bench for node_tag_issuer: directed commands push their expected beats and
// done events into a queue; an independent monitor pops and compares every
// transferred beat and every done pulse, and checks bus hold and idle NULL.
module tb_node_tag_issuer;

    localparam int DW = 16;
    localparam int BW = 128;
    localparam int TW = 16;
    localparam int CW = 12;
    localparam int AW = 10;
    localparam logic [TW-1:0] NULLT = 16'hFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] cmd_tag_a, cmd_stride_a, cmd_tag_b, cmd_stride_b;
    logic [CW-1:0] cmd_count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [BW-1:0] mem_data_a, mem_data_b;
    logic          bus_stall;
    logic          bus_valid;
    logic [TW-1:0] tagA_OUT, tagB_OUT;
    logic [BW-1:0] d0_OUT, d1_OUT;
    logic          done;
    logic          err_null_tag;

    always #5 clk = ~clk;

    node_tag_issuer #(
        .data_width(DW), .block_width(BW), .tag_width(TW),
        .count_width(CW), .addr_width(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tag_a(cmd_tag_a), .cmd_stride_a(cmd_stride_a),
        .cmd_tag_b(cmd_tag_b), .cmd_stride_b(cmd_stride_b),
        .cmd_count(cmd_count),
        .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
        .bus_stall(bus_stall), .bus_valid(bus_valid),
        .tagA_OUT(tagA_OUT), .tagB_OUT(tagB_OUT),
        .d0_OUT(d0_OUT), .d1_OUT(d1_OUT),
        .done(done), .err_null_tag(err_null_tag)
    );

    // Scratchpad contents are a fixed function of address and port.
    function automatic logic [BW-1:0] mem_a(input logic [AW-1:0] a);
        logic [BW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = {6'(i), a} ^ 16'h1234;
        return r;
    endfunction

    function automatic logic [BW-1:0] mem_b(input logic [AW-1:0] a);
        logic [BW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = {6'(i + 8), a} ^ 16'h8421;
        return r;
    endfunction

    // Scratchpad model: data only valid the cycle after a strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_data_a <= mem_a(mem_addr_a);
            mem_data_b <= mem_b(mem_addr_b);
        end else begin
            mem_data_a <= {8{16'hDEAD}};
            mem_data_b <= {8{16'hBEEF}};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_done;
        logic [TW-1:0] ta;
        logic [TW-1:0] tb;
        int            ref_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_cyc_q[$];
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   last_xfer = -100;
    int   last_done = -100;

    task automatic chk(input string name, input bit ok,
                       input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected beats of a command (NULL-tag beats produce nothing), then done.
    task automatic push_cmd(input logic [TW-1:0] ta, input logic [TW-1:0] sa,
                            input logic [TW-1:0] tb, input logic [TW-1:0] sb,
                            input int cnt, input int done_ref);
        exp_t e;
        logic [TW-1:0] a, b;
        a = ta;
        b = tb;
        for (int i = 0; i < cnt; i++) begin
            if (a != NULLT && b != NULLT) begin
                e.is_done = 0; e.ta = a; e.tb = b; e.ref_cyc = 0;
                exp_q.push_back(e);
            end
            a = a + sa;
            b = b + sb;
        end
        e.is_done = 1; e.ta = NULLT; e.tb = NULLT; e.ref_cyc = done_ref;
        exp_q.push_back(e);
    endtask

    task automatic issue_cmd(input logic [TW-1:0] ta, input logic [TW-1:0] sa,
                             input logic [TW-1:0] tb, input logic [TW-1:0] sb,
                             input int cnt, output int acc);
        bit ok;
        cmd_tag_a = ta; cmd_stride_a = sa; cmd_tag_b = tb; cmd_stride_b = sb;
        cmd_count = CW'(cnt);
        cmd_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        chk("cmd_accept_timeout", ok, 0, 1);
        cmd_valid = 1'b0;
        acc = cyc;
        push_cmd(ta, sa, tb, sb, cnt, (cnt == 0) ? acc : -1);
    endtask

    task automatic wait_done();
        int start;
        bit seen;
        start = done_cnt;
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = (done_cnt > start);
        end
        chk("done_timeout", seen, 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pops, hold-while-stalled and idle-NULL checks.
    initial begin : monitor
        bit            prev_valid, prev_stall;
        logic [TW-1:0] p_ta, p_tb;
        logic [BW-1:0] p_d0, p_d1;
        exp_t          e;
        int            want;
        prev_valid = 0;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
            end else begin
                if (prev_valid && prev_stall) begin
                    chk("hold_stable",
                        bus_valid && tagA_OUT == p_ta && tagB_OUT == p_tb &&
                        d0_OUT == p_d0 && d1_OUT == p_d1,
                        {bus_valid, tagA_OUT, tagB_OUT}, {1'b1, p_ta, p_tb});
                end
                if (bus_valid && !bus_stall) begin
                    $display("beat cyc=%0d tagA=%h tagB=%h", cyc, tagA_OUT, tagB_OUT);
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        chk("unexpected_beat", 0, {tagA_OUT, tagB_OUT}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_tags", tagA_OUT == e.ta && tagB_OUT == e.tb,
                            {tagA_OUT, tagB_OUT}, {e.ta, e.tb});
                        chk("beat_d0", d0_OUT == mem_a(e.ta[AW-1:0]), d0_OUT, mem_a(e.ta[AW-1:0]));
                        chk("beat_d1", d1_OUT == mem_b(e.tb[AW-1:0]), d1_OUT, mem_b(e.tb[AW-1:0]));
                    end
                    xfer_cyc_q.push_back(cyc);
                    last_xfer = cyc;
                end
                if (!bus_valid) begin
                    chk("idle_null", tagA_OUT == NULLT && tagB_OUT == NULLT,
                        {tagA_OUT, tagB_OUT}, {NULLT, NULLT});
                end
                if (done) begin
                    $display("done cyc=%0d", cyc);
                    done_cnt++;
                    last_done = cyc;
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        chk("unexpected_done", 0, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        want = (e.ref_cyc < 0) ? last_xfer + 1 : e.ref_cyc;
                        chk("done_time", cyc == want, cyc, want);
                    end
                end
                prev_valid = bus_valid;
                prev_stall = bus_stall;
                p_ta = tagA_OUT; p_tb = tagB_OUT; p_d0 = d0_OUT; p_d1 = d1_OUT;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int  acc, base;
        bit  ok;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_tag_a = '0; cmd_stride_a = '0; cmd_tag_b = '0; cmd_stride_b = '0;
        cmd_count = '0;
        bus_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready == 1'b1, cmd_ready, 1);
        chk("rst_rd_en", mem_rd_en == 1'b0, mem_rd_en, 0);
        chk("rst_valid", bus_valid == 1'b0, bus_valid, 0);
        chk("rst_tags", tagA_OUT == NULLT && tagB_OUT == NULLT, {tagA_OUT, tagB_OUT}, {NULLT, NULLT});
        chk("rst_data", d0_OUT == '0 && d1_OUT == '0, d0_OUT | d1_OUT, 0);
        chk("rst_done_err", done == 1'b0 && err_null_tag == 1'b0, {done, err_null_tag}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: no stall, latency and back-to-back beats.
        base = xfer_cyc_q.size();
        issue_cmd(16'h0010, 16'h0001, 16'h0100, 16'h0002, 4, acc);
        wait_done();
        chk("t1_beats", xfer_cyc_q.size() - base == 4, xfer_cyc_q.size() - base, 4);
        if (xfer_cyc_q.size() - base == 4) begin
            for (int i = 0; i < 4; i++)
                chk("t1_beat_cycle", xfer_cyc_q[base + i] == acc + 2 + i,
                    xfer_cyc_q[base + i], acc + 2 + i);
        end

        // T2: same command with the bus stalled while beat 1 is presented.
        base = xfer_cyc_q.size();
        issue_cmd(16'h0010, 16'h0001, 16'h0100, 16'h0002, 4, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_stall = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus_stall = 1'b0;
        wait_done();
        chk("t2_beats", xfer_cyc_q.size() - base == 4, xfer_cyc_q.size() - base, 4);

        // T3: zero-length command.
        base = xfer_cyc_q.size();
        issue_cmd(16'h0007, 16'h0001, 16'h0008, 16'h0001, 0, acc);
        wait_done();
        chk("t3_no_beats", xfer_cyc_q.size() == base, xfer_cyc_q.size() - base, 0);

        // T4: tag A wraps through NULL.
        base = xfer_cyc_q.size();
        issue_cmd(16'hFFFE, 16'h0001, 16'h0020, 16'h0001, 3, acc);
        wait_done();
        chk("t4_beats", xfer_cyc_q.size() - base == 2, xfer_cyc_q.size() - base, 2);
        chk("t4_err", err_null_tag == 1'b1, err_null_tag, 1);

        // T5: reset after beat 2 of an 8-beat command.
        base = xfer_cyc_q.size();
        issue_cmd(16'h0200, 16'h0001, 16'h0300, 16'h0001, 8, acc);
        chk("t5_err_cleared", err_null_tag == 1'b0, err_null_tag, 0);
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = (xfer_cyc_q.size() - base >= 2);
        end
        chk("t5_beat2_timeout", ok, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("t5_valid", bus_valid == 1'b0, bus_valid, 0);
        chk("t5_tags", tagA_OUT == NULLT && tagB_OUT == NULLT, {tagA_OUT, tagB_OUT}, {NULLT, NULLT});
        chk("t5_ready", cmd_ready == 1'b1, cmd_ready, 1);
        chk("t5_no_done", done == 1'b0, done, 0);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue_cmd(16'h0040, 16'h0003, 16'h0041, 16'h0003, 3, acc);
        wait_done();

        // T6: cmd_valid held; second command only after the first's done.
        cmd_tag_a = 16'h0005; cmd_stride_a = 16'h0001;
        cmd_tag_b = 16'h0006; cmd_stride_b = 16'h0001;
        cmd_count = CW'(2);
        cmd_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        chk("t6_accept_a", ok, 0, 1);
        push_cmd(16'h0005, 16'h0001, 16'h0006, 16'h0001, 2, -1);
        cmd_tag_a = 16'h0080; cmd_stride_a = 16'h0010;
        cmd_tag_b = 16'h0081; cmd_stride_b = 16'h0010;
        cmd_count = CW'(3);
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = cmd_ready;
        end
        chk("t6_ready_after_done", ok && cyc == last_done + 1, cyc, last_done + 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        push_cmd(16'h0080, 16'h0010, 16'h0081, 16'h0010, 3, -1);
        wait_done();

        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("queue_empty", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
